run_ctrl: RTL and testbench
===========================

# run_ctrl

Parametrised run controller for the BasicProcessor family. It replaces the fixed single-program Start/Ack/CycleCt logic with a sequencer that supports:
- selection among `NUM_PROGS` program entry points;
- per-program PC load and core run-enable gating;
- a saturating cycle counter, an optional watchdog timeout, and a completed-run counter.

It sits between the bench (Start/Ack) and the core (ProgCtr load port, Ctrl halt flag).

## Interface
Parameters:
- `PC_W`, 10, program counter width.
- `NUM_PROGS`, 3, number of selectable programs (≥1).
- `SEL_W`, 2, width of `ProgSel` (≥ clog2(`NUM_PROGS`), ≥1).
- `CT_W`, 16, cycle counter width.
- `TIMEOUT`, 0, watchdog limit in RUN cycles; 0 disables the watchdog.
- `RUNS_W`, 8, completed-run counter width.

Ports:
- `Clk`  in  1  clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request to (re)start; level-sampled.
- `ProgSel`  in  `SEL_W`  program index, captured in IDLE/DONE when `Start`=1.
- `ProgBase`  in  `NUM_PROGS*PC_W`  entry addresses; slice i = bits [i*PC_W +: PC_W].
- `CoreDone`  in  1  halt flag from core decoder.
- `PcLoad`  out  1  force core PC to `PcLoadVal` this cycle.
- `PcLoadVal`  out  `PC_W`  entry address of the selected program.
- `CoreRun`  out  1  core advance enable.
- `Ack`  out  1  program finished (normal, timeout or bad select).
- `TimedOut`  out  1  last run was ended by the watchdog.
- `BadSel`  out  1  last `ProgSel` was ≥ `NUM_PROGS`.
- `CycleCt`  out  `CT_W`  RUN cycles of the current or last run.
- `RunCount`  out  `RUNS_W`  normally completed runs since reset.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset (any state, any cycle):
  - next state is IDLE;
  - all outputs are 0, including `CycleCt`, `RunCount` and the captured selection.
- IDLE:
  - `Start`=1 with `ProgSel` < `NUM_PROGS`: capture `ProgSel`, clear `CycleCt`, `TimedOut`, `BadSel`; go to LOAD.
  - `Start`=1 with `ProgSel` ≥ `NUM_PROGS`: set `BadSel`, clear `CycleCt`; go to DONE.
  - Otherwise stay in IDLE.
- LOAD:
  - `PcLoad`=1; `PcLoadVal` is the captured slice of `ProgBase`; `CoreRun`=0.
  - The state holds while `Start`=1. The core is held at its entry address for as long as Start is asserted.
  - `Start`=0: go to RUN.
- RUN:
  - `CoreRun`=1; `CycleCt` increments by 1 each cycle and saturates at all-ones (never wraps).
  - `CoreDone`=1: go to DONE; `RunCount` += 1, wrapping modulo 2^`RUNS_W`. The cycle in which `CoreDone` is seen is counted.
  - Otherwise, if `TIMEOUT`≠0 and the incremented `CycleCt` equals `TIMEOUT`: set `TimedOut`; go to DONE; `RunCount` unchanged.
  - If `CoreDone`=1 and the timeout fire in the same cycle, `CoreDone` wins: `TimedOut` stays 0 and `RunCount` increments.
  - `Start`=1 in RUN is ignored.
- DONE:
  - `Ack`=1, `CoreRun`=0; `CycleCt`, `TimedOut` and `BadSel` hold.
  - `Start`=1: handled exactly as in IDLE (capture, clear flags, go to LOAD or DONE). `Ack` falls the cycle after Start is sampled, except when the new select is also bad.
- `PcLoadVal` is driven only in LOAD and is 0 otherwise.
- `PcLoad` and `CoreRun` are never both 1.

## Timing
- All outputs are registered state or decodes of the state register. There is no combinational path from `Start` or `CoreDone` to any output.
- Start sampled at edge N in IDLE/DONE: `PcLoad`=1 from cycle N+1.
- Start falls before edge M: `CoreRun`=1 from cycle M+1.
- Minimum LOAD length is 1 cycle.
- `CoreDone` sampled at edge K in RUN: `Ack`=1 and `CoreRun`=0 from cycle K+1. `CycleCt` then includes cycle K.
- Timeout with `TIMEOUT`=T: exactly T RUN cycles elapse, then `Ack`=1 and `TimedOut`=1, with `CycleCt`=T.
- `Reset` takes priority over `Start` and `CoreDone` in the same cycle.

## Test plan
- Reset then idle: hold `Reset` 2 cycles, then 5 idle cycles -> every output is 0 throughout; state is IDLE.
- Normal run: `ProgBase`={prog2=0x180, prog1=0x040, prog0=0x000}. Start=1 with ProgSel=1 for 3 cycles -> `PcLoad`=1 for 3 cycles with `PcLoadVal`=0x040. Assert `CoreDone` on the 20th RUN cycle -> `Ack`=1, `CycleCt`=20, `RunCount`=1, `TimedOut`=0.
- Watchdog: `TIMEOUT`=8, `CoreDone` held 0 -> exactly 8 `CoreRun` cycles, then `Ack`=1, `TimedOut`=1, `CycleCt`=8, `RunCount` unchanged.
- Tie: `TIMEOUT`=8 with `CoreDone`=1 on RUN cycle 8 -> `TimedOut`=0, `RunCount` increments.
- Bad select and back-to-back: ProgSel=3 with `NUM_PROGS`=3 -> `BadSel`=1 and `Ack`=1 with no `PcLoad`. Then Start with ProgSel=2 from DONE -> `Ack` drops, `BadSel`=0, `PcLoadVal`=0x180.
- Saturation and mid-run reset: `CT_W`=4 with a 20-cycle run -> `CycleCt` holds at 15. Assert `Reset` during RUN -> next cycle everything is 0 and state is IDLE.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller for the BasicProcessor family: selects a program entry point,
// holds the core at it while Start is high, then gates the core until it halts or times out.
module run_ctrl #(
    parameter int PC_W      = 10,
    parameter int NUM_PROGS = 3,
    parameter int SEL_W     = 2,
    parameter int CT_W      = 16,
    parameter int TIMEOUT   = 0,
    parameter int RUNS_W    = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [SEL_W-1:0]        ProgSel,
    input  logic [NUM_PROGS*PC_W-1:0] ProgBase,
    input  logic                    CoreDone,
    output logic                    PcLoad,
    output logic [PC_W-1:0]         PcLoadVal,
    output logic                    CoreRun,
    output logic                    Ack,
    output logic                    TimedOut,
    output logic                    BadSel,
    output logic [CT_W-1:0]         CycleCt,
    output logic [RUNS_W-1:0]       RunCount
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CT_W-1:0] CT_MAX = '1;
    // A limit the counter can never reach (it saturates first) leaves the watchdog off.
    localparam bit TO_EN = (TIMEOUT > 0) &&
                           ((CT_W >= 32) || (64'(TIMEOUT) < (64'd1 << CT_W)));
    localparam logic [CT_W-1:0] TO_VAL = CT_W'(TIMEOUT);

    state_t state, stateNext;
    logic [SEL_W-1:0]  selReg, selNext;
    logic [CT_W-1:0]   cycleCt, cycleNext, cycleInc;
    logic              timedOut, timedOutNext;
    logic              badSel, badSelNext;
    logic [RUNS_W-1:0] runCount, runNext;
    logic              selOk;

    assign selOk    = int'(ProgSel) < NUM_PROGS;
    assign cycleInc = (cycleCt == CT_MAX) ? cycleCt : cycleCt + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            selReg   <= '0;
            cycleCt  <= '0;
            timedOut <= 1'b0;
            badSel   <= 1'b0;
            runCount <= '0;
        end else begin
            state    <= stateNext;
            selReg   <= selNext;
            cycleCt  <= cycleNext;
            timedOut <= timedOutNext;
            badSel   <= badSelNext;
            runCount <= runNext;
        end
    end

    always_comb begin
        stateNext    = state;
        selNext      = selReg;
        cycleNext    = cycleCt;
        timedOutNext = timedOut;
        badSelNext   = badSel;
        runNext      = runCount;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    cycleNext    = '0;
                    timedOutNext = 1'b0;
                    if (selOk) begin
                        selNext    = ProgSel;
                        badSelNext = 1'b0;
                        stateNext  = LOAD;
                    end else begin
                        badSelNext = 1'b1;
                        stateNext  = DONE;
                    end
                end
            end
            LOAD: begin
                if (!Start) stateNext = RUN;
            end
            RUN: begin
                cycleNext = cycleInc;
                // A halt in the same cycle as the watchdog counts as a normal completion.
                if (CoreDone) begin
                    runNext   = runCount + 1'b1;
                    stateNext = DONE;
                end else if (TO_EN && (cycleInc == TO_VAL)) begin
                    timedOutNext = 1'b1;
                    stateNext    = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign PcLoad    = (state == LOAD);
    assign PcLoadVal = (state == LOAD) ? ProgBase[selReg*PC_W +: PC_W] : '0;
    assign CoreRun   = (state == RUN);
    assign Ack       = (state == DONE);
    assign TimedOut  = timedOut;
    assign BadSel    = badSel;
    assign CycleCt   = cycleCt;
    assign RunCount  = runCount;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances (no watchdog, watchdog of 8, 4-bit counter) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_run_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, Start, CoreDone;
    logic [1:0]  ProgSel;
    logic [29:0] ProgBase;

    logic        pclA, runA, ackA, toA, badA;
    logic [9:0]  pcvA;
    logic [15:0] ctA;
    logic [7:0]  rcA;
    logic        pclB, runB, ackB, toB, badB;
    logic [9:0]  pcvB;
    logic [15:0] ctB;
    logic [7:0]  rcB;
    logic        pclC, runC, ackC, toC, badC;
    logic [9:0]  pcvC;
    logic [3:0]  ctC;
    logic [7:0]  rcC;

    run_ctrl #(.TIMEOUT(0)) dutA (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .ProgBase(ProgBase),
        .CoreDone(CoreDone), .PcLoad(pclA), .PcLoadVal(pcvA), .CoreRun(runA), .Ack(ackA),
        .TimedOut(toA), .BadSel(badA), .CycleCt(ctA), .RunCount(rcA));

    run_ctrl #(.TIMEOUT(8)) dutB (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .ProgBase(ProgBase),
        .CoreDone(CoreDone), .PcLoad(pclB), .PcLoadVal(pcvB), .CoreRun(runB), .Ack(ackB),
        .TimedOut(toB), .BadSel(badB), .CycleCt(ctB), .RunCount(rcB));

    run_ctrl #(.CT_W(4), .TIMEOUT(0)) dutC (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .ProgBase(ProgBase),
        .CoreDone(CoreDone), .PcLoad(pclC), .PcLoadVal(pcvC), .CoreRun(runC), .Ack(ackC),
        .TimedOut(toC), .BadSel(badC), .CycleCt(ctC), .RunCount(rcC));

    // Model phase: 0 waiting, 1 holding entry address, 2 running, 3 finished.
    typedef struct {
        int     phase;
        int     sel;
        longint cyc;
        bit     to;
        bit     bad;
        int     runs;
    } mdl_t;

    mdl_t m [3];
    int nEval = 0;
    int nFail = 0;
    int cycNo = 0;

    function automatic int tmoOf(input int i);
        return (i == 1) ? 8 : 0;
    endfunction

    function automatic longint ctMaxOf(input int i);
        return (i == 2) ? 64'd15 : 64'd65535;
    endfunction

    function automatic int baseOf(input int s);
        case (s)
            0:       return 'h000;
            1:       return 'h040;
            default: return 'h180;
        endcase
    endfunction

    function automatic mdl_t step(input mdl_t cur, input int i, input bit r, input bit s,
                                  input int sel, input bit d);
        mdl_t n = cur;
        longint c;
        if (r) begin
            n.phase = 0; n.sel = 0; n.cyc = 0; n.to = 0; n.bad = 0; n.runs = 0;
        end else if (cur.phase == 0 || cur.phase == 3) begin
            if (s) begin
                n.cyc = 0;
                n.to  = 0;
                if (sel < 3) begin
                    n.sel = sel; n.bad = 0; n.phase = 1;
                end else begin
                    n.bad = 1; n.phase = 3;
                end
            end
        end else if (cur.phase == 1) begin
            if (!s) n.phase = 2;
        end else begin
            c = cur.cyc + 1;
            if (c > ctMaxOf(i)) c = ctMaxOf(i);
            n.cyc = c;
            if (d) begin
                n.runs  = (cur.runs + 1) % 256;
                n.phase = 3;
            end else if (tmoOf(i) != 0 && c == tmoOf(i)) begin
                n.to    = 1;
                n.phase = 3;
            end
        end
        return n;
    endfunction

    function automatic logic [39:0] packOut(input logic pcl, input logic [9:0] pcv,
                                            input logic run, input logic ack, input logic to,
                                            input logic bad, input logic [15:0] ct,
                                            input logic [7:0] rc);
        return {1'b0, pcl, pcv, run, ack, to, bad, ct, rc};
    endfunction

    function automatic logic [39:0] expOf(input mdl_t x);
        logic [9:0] pcv;
        pcv = (x.phase == 1) ? 10'(baseOf(x.sel)) : 10'd0;
        return packOut(x.phase == 1, pcv, x.phase == 2, x.phase == 3, x.to, x.bad,
                       16'(x.cyc), 8'(x.runs));
    endfunction

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        nEval++;
        assert (act === exp) else begin
            nFail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycNo, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit s, input logic [1:0] sel, input bit d);
        Reset = r; Start = s; ProgSel = sel; CoreDone = d;
        @(posedge Clk);
        for (int i = 0; i < 3; i++) m[i] = step(m[i], i, r, s, int'(sel), d);
        @(negedge Clk);
        cycNo++;
        chk("dutA outputs", packOut(pclA, pcvA, runA, ackA, toA, badA, ctA, rcA), expOf(m[0]));
        chk("dutB outputs", packOut(pclB, pcvB, runB, ackB, toB, badB, ctB, rcB), expOf(m[1]));
        chk("dutC outputs", packOut(pclC, pcvC, runC, ackC, toC, badC, {12'd0, ctC}, rcC),
            expOf(m[2]));
    endtask

    initial begin
        ProgBase = {10'h180, 10'h040, 10'h000};
        Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; CoreDone = 1'b0;
        for (int i = 0; i < 3; i++) m[i] = step(m[i], i, 1'b1, 1'b0, 0, 1'b0);

        // Reset then idle
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);

        // Normal run on program 1: three LOAD cycles, halt on the 20th RUN cycle
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 1, 0);
            chk("load addr", 40'(pcvA), 40'h040);
        end
        tick(0, 0, 1, 0);
        for (int k = 0; k < 19; k++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("normal CycleCt", 40'(ctA), 40'd20);
        chk("normal RunCount", 40'(rcA), 40'd1);
        chk("normal Ack/TimedOut", {38'd0, ackA, toA}, 40'b10);
        chk("wdog CycleCt", 40'(ctB), 40'd8);
        chk("wdog TimedOut/RunCount", {31'd0, toB, rcB}, {31'd0, 1'b1, 8'd0});
        chk("sat CycleCt", 40'(ctC), 40'd15);

        // Halt and watchdog coincide on RUN cycle 8
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        for (int k = 0; k < 7; k++) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("tie TimedOut", 40'(toB), 40'd0);
        chk("tie RunCount", 40'(rcB), 40'd1);

        // Watchdog alone
        tick(0, 1, 2, 0);
        tick(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) tick(0, 0, 0, 0);
        chk("wdog2 TimedOut/Ack", {38'd0, toB, ackB}, 40'b11);
        chk("wdog2 RunCount", 40'(rcB), 40'd1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // Bad select, then back-to-back restart from DONE
        tick(0, 1, 3, 0);
        chk("bad BadSel/Ack/PcLoad", {37'd0, badA, ackA, pclA}, 40'b110);
        tick(0, 1, 2, 0);
        chk("restart Ack/BadSel", {38'd0, ackA, badA}, 40'b00);
        chk("restart addr", 40'(pcvA), 40'h180);

        // Long run saturates the 4-bit counter, then reset mid-run
        tick(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) tick(0, 0, 0, 0);
        chk("sat hold", 40'(ctC), 40'd15);
        tick(1, 1, 1, 1);
        chk("midrun reset A", packOut(pclA, pcvA, runA, ackA, toA, badA, ctA, rcA), 40'd0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(99) < 2, $urandom_range(99) < 30,
                 2'($urandom_range(3)), $urandom_range(99) < 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nEval, nFail);
        $finish;
    end

endmodule
